// File: rtl/mmu_pkg.sv
// Shared MMU definitions: flush FSM states, flush-mode encodings and the
// opcode/funct constants used to recognise sfence.vma and fence.i.
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } flush_state_e;

  // Bit 1 = vaddr-qualified, bit 0 = ASID-qualified; 00 flushes everything.
  typedef enum logic [1:0] {
    FM_ALL        = 2'b00,
    FM_ASID       = 2'b01,
    FM_VADDR      = 2'b10,
    FM_VADDR_ASID = 2'b11
  } flush_mode_e;

  localparam logic [6:0] SFENCE_FUNCT7 = 7'b0001001;
  localparam logic [2:0] SFENCE_FUNCT3 = 3'b000;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [2:0] FENCEI_FUNCT3 = 3'b001;

  function automatic flush_mode_e sfence_mode(input logic [4:0] rs1, input logic [4:0] rs2);
    return flush_mode_e'({rs1 != 5'd0, rs2 != 5'd0});
  endfunction

endpackage

// File: rtl/flush_ctrl_if.sv
// Flush request/acknowledge bundle between flush_ctrl (master) and the
// TLB channels plus I-cache (slave).
interface flush_ctrl_if #(
  parameter int XLEN    = 64,
  parameter int ASID_W  = 16,
  parameter int NUM_TLB = 2
);

  logic [NUM_TLB-1:0] tlb_flush_req;
  logic [NUM_TLB-1:0] tlb_flush_ack;
  logic [1:0]         tlb_flush_mode;
  logic [XLEN-1:0]    tlb_flush_vaddr;
  logic [ASID_W-1:0]  tlb_flush_asid;
  logic               icache_flush_req;
  logic               icache_flush_ack;

  modport master (
    output tlb_flush_req,
    output tlb_flush_mode,
    output tlb_flush_vaddr,
    output tlb_flush_asid,
    output icache_flush_req,
    input  tlb_flush_ack,
    input  icache_flush_ack
  );

  modport slave (
    input  tlb_flush_req,
    input  tlb_flush_mode,
    input  tlb_flush_vaddr,
    input  tlb_flush_asid,
    input  icache_flush_req,
    output tlb_flush_ack,
    output icache_flush_ack
  );

endinterface

// File: rtl/flush_decode.sv
// Combinational MEM-stage decode of sfence.vma / fence.i and the TLB flush
// mode, with a coincident satp write forcing a full flush.
module flush_decode
  import mmu_pkg::*;
(
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic        satp_we,
  output logic        is_sfence,
  output logic        is_fencei,
  output flush_mode_e mode
);

  always_comb begin
    // NOTE: every output gets a default before any condition so no latch is inferred.
    is_sfence = 1'b0;
    is_fencei = 1'b0;
    mode      = FM_ALL;

    if (mem_valid) begin
      is_sfence = (mem_inst[31:25] == SFENCE_FUNCT7) &&
                  (mem_inst[14:12] == SFENCE_FUNCT3) &&
                  (mem_inst[11:7]  == 5'd0)          &&
                  (mem_inst[6:0]   == OPC_SYSTEM);
      is_fencei = (mem_inst[14:12] == FENCEI_FUNCT3) &&
                  (mem_inst[6:0]   == OPC_MISC_MEM);
    end

    // A satp write invalidates every translation, so it overrides any qualifier.
    if (is_sfence && !satp_we) begin
      mode = sfence_mode(mem_inst[19:15], mem_inst[24:20]);
    end
  end

endmodule

// File: rtl/flush_ctrl.sv
// MEM-stage flush controller: stalls the pipe on sfence.vma / fence.i / satp
// writes, runs the TLB and I-cache flush handshake, then pulses pipe_flush.
module flush_ctrl
  import mmu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ASID_W      = 16,
  parameter int NUM_TLB     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [31:0]     mem_inst,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [XLEN-1:0] mem_rs1_val,
  input  logic [XLEN-1:0] mem_rs2_val,
  input  logic            satp_we,
  flush_ctrl_if.master    flush_if,
  output logic            stall,
  output logic            pipe_flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            timeout_err
);

  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int PEND_W = NUM_TLB + 1;

  logic        is_sfence;
  logic        is_fencei;
  flush_mode_e dec_mode;
  logic        tlb_trig;
  logic        trigger;

  flush_state_e      state_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  flush_mode_e       mode_q;
  logic [XLEN-1:0]   vaddr_q;
  logic [ASID_W-1:0] asid_q;
  logic [XLEN-1:0]   redirect_q;
  logic              pipe_flush_q;
  logic              timeout_q;
  logic [PEND_W-1:0] ack_vec;
  logic              unused_rs2_hi;

  flush_decode u_decode (
    .mem_valid (mem_valid),
    .mem_inst  (mem_inst),
    .satp_we   (satp_we),
    .is_sfence (is_sfence),
    .is_fencei (is_fencei),
    .mode      (dec_mode)
  );

  assign tlb_trig = is_sfence | satp_we;
  assign trigger  = tlb_trig | is_fencei;

  // Pending bit NUM_TLB tracks the I-cache; the rest are the TLB channels.
  assign ack_vec   = {flush_if.icache_flush_ack, flush_if.tlb_flush_ack};
  assign pending_d = pending_q & ~ack_vec;
  assign timer_d   = timer_q + TMR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      timer_q      <= '0;
      mode_q       <= FM_ALL;
      vaddr_q      <= '0;
      asid_q       <= '0;
      redirect_q   <= '0;
      pipe_flush_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pipe_flush_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            mode_q     <= dec_mode;
            vaddr_q    <= mem_rs1_val;
            asid_q     <= mem_rs2_val[ASID_W-1:0];
            redirect_q <= mem_pc + XLEN'(4);
            pending_q  <= {is_fencei, {NUM_TLB{tlb_trig}}};
            timer_q    <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer_q <= timer_d;
          if (pending_d == '0) begin
            pending_q    <= '0;
            pipe_flush_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            // An agent that never answers must not hang the pipeline forever.
            pending_q    <= '0;
            timeout_q    <= 1'b1;
            pipe_flush_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            pending_q <= pending_d;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flush_if.tlb_flush_req    = pending_q[NUM_TLB-1:0];
  assign flush_if.icache_flush_req = pending_q[NUM_TLB];
  assign flush_if.tlb_flush_mode   = mode_q;
  assign flush_if.tlb_flush_vaddr  = vaddr_q;
  assign flush_if.tlb_flush_asid   = asid_q;

  // Stall must rise in the trigger cycle itself, before the FSM has moved.
  assign stall       = (trigger && (state_q == ST_IDLE)) || (state_q != ST_IDLE);
  assign pipe_flush  = pipe_flush_q;
  assign redirect_pc = redirect_q;
  assign timeout_err = timeout_q;

  assign unused_rs2_hi = ^mem_rs2_val[XLEN-1:ASID_W];

endmodule

// File: tb/tb_flush_ctrl.sv
// Randomised + directed bench for flush_ctrl against a cycle-indexed
// transaction model of the flush handshake.
module tb_flush_ctrl;

  localparam int XLEN        = 64;
  localparam int ASID_W      = 16;
  localparam int NUM_TLB     = 2;
  localparam int TIMEOUT_CYC = 255;
  localparam logic [31:0] FENCE_I = 32'h0000_100F;

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        satp;
    logic [1:0]  tack;
    logic        iack;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_inst;
  logic [63:0] mem_pc;
  logic [63:0] mem_rs1_val;
  logic [63:0] mem_rs2_val;
  logic        satp_we;
  logic        stall;
  logic        pipe_flush;
  logic [63:0] redirect_pc;
  logic        timeout_err;

  flush_ctrl_if #(.XLEN(XLEN), .ASID_W(ASID_W), .NUM_TLB(NUM_TLB)) fif ();

  flush_ctrl #(
    .XLEN(XLEN), .ASID_W(ASID_W), .NUM_TLB(NUM_TLB), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_inst    (mem_inst),
    .mem_pc      (mem_pc),
    .mem_rs1_val (mem_rs1_val),
    .mem_rs2_val (mem_rs2_val),
    .satp_we     (satp_we),
    .flush_if    (fif),
    .stall       (stall),
    .pipe_flush  (pipe_flush),
    .redirect_pc (redirect_pc),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: one accepted flush at a time, tracked by cycle index.
  bit          m_busy;
  int          m_t;
  int          m_t0;
  int          m_done_at;
  logic [2:0]  m_outst;
  bit          m_err;
  logic [1:0]  m_mode;
  logic [63:0] m_vaddr;
  logic [15:0] m_asid;
  logic [63:0] m_rpc;
  int          pf_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s.v = 1'b0; s.inst = 32'h0000_0013; s.pc = '0; s.rs1 = '0; s.rs2 = '0;
    s.satp = 1'b0; s.tack = 2'b00; s.iack = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] sfence(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0001001, rs2, rs1, 3'b000, 5'b00000, 7'b1110011};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done_at = -1; m_outst = '0; m_err = 0;
    m_mode = '0; m_vaddr = '0; m_asid = '0; m_rpc = '0;
  endtask

  // Drive one cycle of stimulus, compare every output, then advance the model.
  task automatic apply(input stim_t s);
    bit is_sf, is_fi, tlb_trig, trig, waiting;
    @(negedge clk);
    mem_valid = s.v; mem_inst = s.inst; mem_pc = s.pc;
    mem_rs1_val = s.rs1; mem_rs2_val = s.rs2; satp_we = s.satp;
    fif.tlb_flush_ack = s.tack; fif.icache_flush_ack = s.iack;
    #1;
    is_sf    = s.v && ((s.inst & 32'hFE00_7FFF) == 32'h1200_0073);
    is_fi    = s.v && ((s.inst & 32'h0000_707F) == 32'h0000_100F);
    tlb_trig = is_sf || s.satp;
    trig     = tlb_trig || is_fi;
    waiting  = m_busy && (m_done_at < 0);

    check("stall",       64'(stall),                64'(m_busy || trig));
    check("pipe_flush",  64'(pipe_flush),           64'(m_busy && (m_t == m_done_at)));
    check("tlb_req",     64'(fif.tlb_flush_req),    waiting ? 64'(m_outst[1:0]) : 64'd0);
    check("ic_req",      64'(fif.icache_flush_req), waiting ? 64'(m_outst[2]) : 64'd0);
    check("timeout_err", 64'(timeout_err),          64'(m_err));
    check("mode",        64'(fif.tlb_flush_mode),   64'(m_mode));
    check("vaddr",       fif.tlb_flush_vaddr,       m_vaddr);
    check("asid",        64'(fif.tlb_flush_asid),   64'(m_asid));
    check("redirect_pc", redirect_pc,               m_rpc);
    if (pipe_flush) pf_count++;

    if (!m_busy) begin
      if (trig) begin
        m_busy = 1; m_t0 = m_t; m_done_at = -1;
        m_outst = {is_fi, tlb_trig, tlb_trig};
        if (s.satp || !is_sf) m_mode = 2'b00;
        else m_mode = {s.inst[19:15] != 5'd0, s.inst[24:20] != 5'd0};
        m_vaddr = s.rs1; m_asid = s.rs2[15:0]; m_rpc = s.pc + 64'd4;
      end
    end else if (m_done_at < 0) begin
      m_outst = m_outst & ~{s.iack, s.tack};
      if (m_outst == 3'b000) m_done_at = m_t + 1;
      else if (m_t - m_t0 == TIMEOUT_CYC) begin
        m_err = 1; m_outst = '0; m_done_at = m_t + 1;
      end
    end else if (m_t == m_done_at) begin
      m_busy = 0; m_done_at = -1;
    end
    m_t++;
  endtask

  function automatic stim_t rand_stim(input bit stuck);
    stim_t s;
    s = idle_stim();
    s.v   = ($urandom_range(0, 3) != 0);
    s.pc  = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) s.pc = 64'hFFFF_FFFF_FFFF_FFFC;
    s.rs1 = {$urandom, $urandom};
    s.rs2 = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0, 1:    s.inst = sfence(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      2:       s.inst = FENCE_I;
      3:       s.inst = $urandom;
      default: s.inst = 32'h0000_0013;
    endcase
    s.satp    = ($urandom_range(0, 11) == 0);
    s.tack[0] = ($urandom_range(0, 3) == 0);
    s.tack[1] = stuck ? 1'b0 : ($urandom_range(0, 3) == 0);
    s.iack    = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    mem_valid = 0; mem_inst = 32'h13; mem_pc = '0; mem_rs1_val = '0; mem_rs2_val = '0;
    satp_we = 0; fif.tlb_flush_ack = '0; fif.icache_flush_ack = 1'b0;
    m_t = 0; pf_count = 0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",    64'(stall), 64'd0);
    check("rst_req",      64'({fif.icache_flush_req, fif.tlb_flush_req}), 64'd0);
    check("rst_pflush",   64'(pipe_flush), 64'd0);
    check("rst_timeout",  64'(timeout_err), 64'd0);
    check("rst_mode",     64'(fif.tlb_flush_mode), 64'd0);
    check("rst_vaddr",    fif.tlb_flush_vaddr, 64'd0);
    check("rst_redirect", redirect_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // sfence.vma x0,x0: ch0 acked in the first WAIT cycle, ch1 in the fourth.
    s = idle_stim(); s.v = 1; s.inst = sfence(0, 0); s.pc = 64'h1000; apply(s);
    s = idle_stim(); s.tack = 2'b01; apply(s);
    check("d1_req", 64'(fif.tlb_flush_req), 64'h3);
    check("d1_mode", 64'(fif.tlb_flush_mode), 64'h0);
    apply(idle_stim()); apply(idle_stim());
    s = idle_stim(); s.tack = 2'b10; apply(s);
    apply(idle_stim());
    check("d1_pflush", 64'(pipe_flush), 64'h1);
    check("d1_redirect", redirect_pc, 64'h1004);
    apply(idle_stim());
    check("d1_stall_off", 64'(stall), 64'h0);

    // sfence.vma a0,a1 with both acks at once, then a0,x0.
    s = idle_stim(); s.v = 1; s.inst = sfence(10, 11); s.pc = 64'h2000;
    s.rs1 = 64'h8000_1000; s.rs2 = 64'h5; apply(s);
    s = idle_stim(); s.tack = 2'b11; apply(s);
    check("d2_mode", 64'(fif.tlb_flush_mode), 64'h3);
    check("d2_vaddr", fif.tlb_flush_vaddr, 64'h8000_1000);
    check("d2_asid", 64'(fif.tlb_flush_asid), 64'h5);
    apply(idle_stim());
    check("d2_pflush", 64'(pipe_flush), 64'h1);
    apply(idle_stim());
    s = idle_stim(); s.v = 1; s.inst = sfence(10, 0); s.rs1 = 64'h4000; apply(s);
    s = idle_stim(); s.tack = 2'b11; apply(s);
    check("d2_mode_va", 64'(fif.tlb_flush_mode), 64'h2);
    apply(idle_stim()); apply(idle_stim());

    // fence.i at the top of the address space: only the I-cache is asked.
    s = idle_stim(); s.v = 1; s.inst = FENCE_I; s.pc = 64'hFFFF_FFFF_FFFF_FFFC; apply(s);
    s = idle_stim(); s.iack = 1; apply(s);
    check("d3_tlb_req", 64'(fif.tlb_flush_req), 64'h0);
    check("d3_ic_req", 64'(fif.icache_flush_req), 64'h1);
    apply(idle_stim());
    check("d3_pflush", 64'(pipe_flush), 64'h1);
    check("d3_redirect_wrap", redirect_pc, 64'h0);
    apply(idle_stim());

    // satp write merged with sfence a0,a1; second trigger while busy; stray ack in IDLE.
    s = idle_stim(); s.v = 1; s.inst = sfence(10, 11); s.satp = 1;
    s.rs1 = 64'hDEAD_0000; s.rs2 = 64'h7; s.pc = 64'h3000; apply(s);
    s = idle_stim(); s.v = 1; s.inst = sfence(10, 11); s.rs1 = 64'h1111; s.pc = 64'h9000; apply(s);
    check("d4_merged_mode", 64'(fif.tlb_flush_mode), 64'h0);
    s = idle_stim(); s.tack = 2'b11; apply(s);
    check("d4_no_relatch", fif.tlb_flush_vaddr, 64'hDEAD_0000);
    apply(idle_stim());
    s = idle_stim(); s.tack = 2'b11; s.iack = 1; apply(s);
    apply(idle_stim());
    check("d4_idle_ack", 64'({stall, fif.tlb_flush_req}), 64'h0);

    // ch1 never answers: timeout, single pipe_flush, sticky error.
    pf_count = 0;
    s = idle_stim(); s.v = 1; s.inst = sfence(0, 0); s.pc = 64'h5000; apply(s);
    s = idle_stim(); s.tack = 2'b01; apply(s);
    for (int i = 0; i < TIMEOUT_CYC + 8; i++) apply(idle_stim());
    check("d5_timeout", 64'(timeout_err), 64'h1);
    check("d5_one_flush", 64'(pf_count), 64'h1);

    // Reset in WAIT aborts immediately; a later ack is ignored.
    s = idle_stim(); s.v = 1; s.inst = sfence(0, 0); apply(s);
    apply(idle_stim()); apply(idle_stim());
    @(negedge clk);
    mem_valid = 0; satp_we = 0; fif.tlb_flush_ack = '0; fif.icache_flush_ack = 0;
    #2 rst = 1'b1;
    #1;
    check("d6_rst_req", 64'({fif.icache_flush_req, fif.tlb_flush_req}), 64'h0);
    check("d6_rst_stall", 64'(stall), 64'h0);
    check("d6_rst_timeout", 64'(timeout_err), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    m_t++;
    s = idle_stim(); s.tack = 2'b11; s.iack = 1; apply(s);
    apply(idle_stim());

    // Random traffic; some blocks starve ch1 to reach the timeout path.
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 400; c++) apply(rand_stim((blk == 2) || (blk == 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
